sdram_port_arb: RTL and testbench

- Client-side requester for the 8-bit edge-triggered SDRAM controller port.
- Arbitrates two requesters onto the single controller rd/we/ready interface:
  - Port A: byte writes from the ROM/ioctl download path.
  - Port B: 16-bit word reads from the CPU, performed as two byte reads.
- Generates correctly spaced rd/we strobes, tracks ready, and returns ack/data per port.
- Sits between the core's loader/CPU logic and the sdram controller instance.

---
 rtl/sdram_port_arb_if.sv | 22 ++
 rtl/sdram_port_arb.sv | 135 +++++++++++++
 tb/tb_sdram_port_arb.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_port_arb_if.sv
// Controller-side bus of the SDRAM port arbiter.
// master: the arbiter (drives address, write data and strobes; sees read data and ready).
// slave:  the SDRAM controller (drives read data and ready).
// Ports: mem_addr[24:0], mem_din[7:0], mem_we, mem_rd, mem_dout[7:0], mem_ready.
interface sdram_port_arb_if;
  logic [24:0] mem_addr;
  logic [7:0]  mem_din;
  logic        mem_we;
  logic        mem_rd;
  logic [7:0]  mem_dout;
  logic        mem_ready;

  modport master (
    output mem_addr, mem_din, mem_we, mem_rd,
    input  mem_dout, mem_ready
  );

  modport slave (
    input  mem_addr, mem_din, mem_we, mem_rd,
    output mem_dout, mem_ready
  );
endinterface

// File: rtl/sdram_port_arb.sv
// Purpose: arbitrates port A byte writes and port B 16-bit reads (two byte reads) onto one
//   edge-triggered 8-bit SDRAM controller port; alternates A/B under contention, A first.
// Latency: strobe rises two cycles after an IDLE grant; ack one cycle after ready completes.
// Backpressure: requests wait in IDLE until mem_ready is high; each WAIT aborts after
//   TIMEOUT_CYCLES cycles, still acking (B returns 16'hFFFF) and setting sticky timeout_err.
// Ports: clk, reset (sync, active high); a_req/a_addr/a_din/a_ack (write port);
//   b_req/b_addr/b_dout/b_ack (word read port); timeout_err; mem (controller bus, master).
module sdram_port_arb #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  a_req,
  input  logic [24:0]           a_addr,
  input  logic [7:0]            a_din,
  output logic                  a_ack,
  input  logic                  b_req,
  input  logic [23:0]           b_addr,
  output logic [15:0]           b_dout,
  output logic                  b_ack,
  output logic                  timeout_err,
  sdram_port_arb_if.master      mem
);

  localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [3:0] {
    IDLE, A_STB, A_WAIT, B_STB0, B_WAIT0, B_GAP, B_STB1, B_WAIT1, GAP
  } state_t;

  state_t        state;
  logic          last_b;   // 1: port B was served last, so A wins the next contention
  logic [CW-1:0] cnt;

  // The controller only reacts at the end of the strobe's first cycle, so ready seen
  // while cnt==0 still belongs to the previous access and is ignored.
  logic done;
  logic tmo;
  assign done = mem.mem_ready && (cnt != '0);
  assign tmo  = (cnt == CW'(TIMEOUT_CYCLES));

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      last_b       <= 1'b1;
      cnt          <= '0;
      a_ack        <= 1'b0;
      b_ack        <= 1'b0;
      b_dout       <= '0;
      timeout_err  <= 1'b0;
      mem.mem_addr <= '0;
      mem.mem_din  <= '0;
      mem.mem_we   <= 1'b0;
      mem.mem_rd   <= 1'b0;
    end else begin
      a_ack <= 1'b0;
      b_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (mem.mem_ready) begin
            if (a_req && (!b_req || last_b)) state <= A_STB;
            else if (b_req)                  state <= B_STB0;
          end
        end
        A_STB: begin
          mem.mem_addr <= a_addr;
          mem.mem_din  <= a_din;
          mem.mem_we   <= 1'b1;
          cnt          <= '0;
          state        <= A_WAIT;
        end
        A_WAIT: begin
          cnt <= cnt + 1'b1;
          if (done || tmo) begin
            // An aborted write is still acked so the loader never stalls.
            mem.mem_we <= 1'b0;
            a_ack      <= 1'b1;
            last_b     <= 1'b0;
            state      <= GAP;
            if (!done) timeout_err <= 1'b1;
          end
        end
        B_STB0: begin
          mem.mem_addr <= {b_addr, 1'b0};
          mem.mem_rd   <= 1'b1;
          cnt          <= '0;
          state        <= B_WAIT0;
        end
        B_WAIT0: begin
          cnt <= cnt + 1'b1;
          if (done) begin
            b_dout[7:0] <= mem.mem_dout;
            mem.mem_rd  <= 1'b0;
            state       <= B_GAP;
          end else if (tmo) begin
            // Abort skips the odd byte and hands back an all-ones word.
            mem.mem_rd  <= 1'b0;
            b_dout      <= 16'hFFFF;
            b_ack       <= 1'b1;
            timeout_err <= 1'b1;
            last_b      <= 1'b1;
            state       <= GAP;
          end
        end
        B_GAP: state <= B_STB1;
        B_STB1: begin
          mem.mem_addr <= {b_addr, 1'b1};
          mem.mem_rd   <= 1'b1;
          cnt          <= '0;
          state        <= B_WAIT1;
        end
        B_WAIT1: begin
          cnt <= cnt + 1'b1;
          if (done) begin
            b_dout[15:8] <= mem.mem_dout;
            mem.mem_rd   <= 1'b0;
            b_ack        <= 1'b1;
            last_b       <= 1'b1;
            state        <= GAP;
          end else if (tmo) begin
            mem.mem_rd  <= 1'b0;
            b_dout      <= 16'hFFFF;
            b_ack       <= 1'b1;
            timeout_err <= 1'b1;
            last_b      <= 1'b1;
            state       <= GAP;
          end
        end
        GAP:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_port_arb.sv
// Directed bench for sdram_port_arb with a small behavioural SDRAM controller model.
module tb_sdram_port_arb;
  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_req, b_req;
  logic [24:0] a_addr;
  logic [7:0]  a_din;
  logic [23:0] b_addr;
  logic        a_ack, b_ack, timeout_err;
  logic [15:0] b_dout;

  sdram_port_arb_if mem_if();

  sdram_port_arb #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_addr(a_addr), .a_din(a_din), .a_ack(a_ack),
    .b_req(b_req), .b_addr(b_addr), .b_dout(b_dout), .b_ack(b_ack),
    .timeout_err(timeout_err), .mem(mem_if)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Controller model: reacts to strobe rising edges on the falling clock edge.
  logic [7:0]  cmem [0:255];
  bit          ctl_on = 0;
  bit          ctl_hang = 0;
  int          ctl_lat = 4;
  int          m_rem = 0;
  logic        m_pwe = 0, m_prd = 0, m_have = 0;
  logic [23:0] m_word = '0;
  logic [7:0]  m_byte = '0;

  initial begin
    for (int i = 0; i < 256; i++) cmem[i] = 8'h00;
    cmem[8'h80] = 8'h34;
    cmem[8'h81] = 8'h12;
    mem_if.mem_ready = 1'b0;
    mem_if.mem_dout  = 8'h00;
    forever begin
      @(negedge clk);
      if (mem_if.mem_we && !m_pwe) cmem[mem_if.mem_addr[7:0]] = mem_if.mem_din;
      if ((mem_if.mem_we && !m_pwe) || (mem_if.mem_rd && !m_prd)) begin
        if (mem_if.mem_rd && m_have && mem_if.mem_addr[24:1] == m_word) m_rem = 0;
        else m_rem = ctl_hang ? 1000000 : ctl_lat;
        if (mem_if.mem_rd) begin
          m_have = 1'b1;
          m_word = mem_if.mem_addr[24:1];
          m_byte = cmem[mem_if.mem_addr[7:0]];
        end
        if (m_rem == 0) mem_if.mem_dout = m_byte;
      end else if (m_rem > 0) begin
        m_rem--;
        if (m_rem == 0) mem_if.mem_dout = m_byte;
      end
      mem_if.mem_ready = ctl_on && (m_rem == 0);
      m_pwe = mem_if.mem_we;
      m_prd = mem_if.mem_rd;
    end
  end

  initial begin
    int hi, bad, acks, rises, ovl, spc, nseq, first;
    int runlen [2];
    logic [24:0] raddr [2];
    logic [15:0] dout;
    logic p_we, p_rd;
    int seq [6];

    reset = 1'b1; a_req = 0; b_req = 0; a_addr = '0; a_din = '0; b_addr = '0;
    tick; tick;
    chk("rst_acks", {30'd0, a_ack, b_ack}, 32'd0);
    chk("rst_strobes", {30'd0, mem_if.mem_we, mem_if.mem_rd}, 32'd0);
    chk("rst_err", {31'd0, timeout_err}, 32'd0);
    chk("rst_data", {b_dout, mem_if.mem_din, 8'd0}, 32'd0);
    chk("rst_addr", {7'd0, mem_if.mem_addr}, 32'd0);
    reset = 1'b0;

    // Startup gating, then the gated write goes through as the port A write.
    a_addr = 25'h000123; a_din = 8'h5A; a_req = 1;
    hi = 0;
    for (int i = 0; i < 100; i++) begin
      tick;
      if (mem_if.mem_we) hi++;
    end
    chk("startup_no_we", hi, 0);
    ctl_on = 1; ctl_lat = 4;
    tick;
    chk("startup_we_not_yet", {31'd0, mem_if.mem_we}, 32'd0);
    tick;
    chk("startup_we_rise", {31'd0, mem_if.mem_we}, 32'd1);
    chk("startup_addr", {7'd0, mem_if.mem_addr}, 32'h123);
    hi = 1; bad = (mem_if.mem_din !== 8'h5A); acks = 0;
    for (int i = 0; i < 30 && acks == 0; i++) begin
      tick;
      if (mem_if.mem_we) begin
        hi++;
        if (mem_if.mem_din !== 8'h5A) bad++;
      end
      if (a_ack) begin
        acks++;
        chk("a_we_low_at_ack", {31'd0, mem_if.mem_we}, 32'd0);
        a_req = 0;
      end
    end
    rises = 0;
    for (int i = 0; i < 10; i++) begin
      tick;
      if (a_ack) acks++;
      if (mem_if.mem_we) rises++;
    end
    chk("a_we_high_cycles", hi, 5);
    chk("a_din_stable", bad, 0);
    chk("a_ack_once", acks, 1);
    chk("a_no_rewrite", rises, 0);
    chk("a_mem_written", {24'd0, cmem[8'h23]}, 32'h5A);

    // Port B: first byte misses (latency 3), second byte hits the same word.
    b_addr = 24'h000040; b_req = 1; ctl_lat = 3;
    p_rd = 0; rises = 0; acks = 0; runlen[0] = 0; runlen[1] = 0;
    raddr[0] = '0; raddr[1] = '0; dout = '0;
    for (int i = 0; i < 60 && acks == 0; i++) begin
      tick;
      if (mem_if.mem_rd && !p_rd) begin
        if (rises < 2) raddr[rises] = mem_if.mem_addr;
        rises++;
      end
      if (mem_if.mem_rd && rises >= 1 && rises <= 2) runlen[rises-1]++;
      p_rd = mem_if.mem_rd;
      if (b_ack) begin
        acks++;
        dout = b_dout;
        b_req = 0;
      end
    end
    for (int i = 0; i < 3; i++) begin
      tick;
      if (b_ack) acks++;
    end
    chk("b_ack_once", acks, 1);
    chk("b_dout", {16'd0, dout}, 32'h1234);
    chk("b_dout_hold", {16'd0, b_dout}, 32'h1234);
    chk("b_rd_edges", rises, 2);
    chk("b_addr_even", {7'd0, raddr[0]}, 32'h80);
    chk("b_addr_odd", {7'd0, raddr[1]}, 32'h81);
    chk("b_miss_len", runlen[0], 4);
    chk("b_hit_len", runlen[1], 2);

    // Contention: both requests held, service must alternate starting with A.
    a_addr = 25'h000200; a_din = 8'h77; b_addr = 24'h000040; a_req = 1; b_req = 1;
    ctl_lat = 2; p_we = 0; p_rd = 0; ovl = 0; spc = 0; nseq = 0;
    for (int i = 0; i < 6; i++) seq[i] = 0;
    for (int i = 0; i < 300 && nseq < 6; i++) begin
      tick;
      if (mem_if.mem_we && mem_if.mem_rd) ovl++;
      if (((mem_if.mem_we && !p_we) || (mem_if.mem_rd && !p_rd)) && (p_we || p_rd)) spc++;
      p_we = mem_if.mem_we;
      p_rd = mem_if.mem_rd;
      if (a_ack && nseq < 6) begin seq[nseq] = 1; nseq++; end
      if (b_ack && nseq < 6) begin seq[nseq] = 2; nseq++; end
      if (nseq == 6) begin a_req = 0; b_req = 0; end
    end
    a_req = 0; b_req = 0;
    for (int i = 0; i < 6; i++) chk($sformatf("arb_order_%0d", i), seq[i], (i % 2 == 0) ? 1 : 2);
    chk("arb_no_overlap", ovl, 0);
    chk("arb_strobe_gap", spc, 0);
    chk("arb_b_dout", {16'd0, b_dout}, 32'h1234);
    tick; tick;

    // Timeout: ready never returns after the first read strobe.
    ctl_hang = 1; b_addr = 24'h000010; b_req = 1;
    p_rd = 0; hi = 0; rises = 0; acks = 0; dout = '0;
    for (int i = 0; i < 60 && acks == 0; i++) begin
      tick;
      if (mem_if.mem_rd) hi++;
      if (mem_if.mem_rd && !p_rd) rises++;
      p_rd = mem_if.mem_rd;
      if (b_ack) begin
        acks++;
        dout = b_dout;
        b_req = 0;
      end
    end
    chk("tmo_ack", acks, 1);
    chk("tmo_dout", {16'd0, dout}, 32'hFFFF);
    chk("tmo_rd_cycles", hi, TMO + 1);
    chk("tmo_single_rd", rises, 1);
    chk("tmo_err_set", {31'd0, timeout_err}, 32'd1);
    ctl_hang = 0; m_rem = 0;
    for (int i = 0; i < 5; i++) tick;
    chk("tmo_err_sticky", {31'd0, timeout_err}, 32'd1);

    // Reset while the first read byte is outstanding.
    ctl_lat = 6; b_addr = 24'h000020; b_req = 1;
    for (int i = 0; i < 20 && !mem_if.mem_rd; i++) tick;
    chk("rst_mid_rd_started", {31'd0, mem_if.mem_rd}, 32'd1);
    reset = 1; b_req = 0;
    tick;
    chk("rst_mid_rd_drop", {31'd0, mem_if.mem_rd}, 32'd0);
    chk("rst_mid_no_ack", {31'd0, b_ack}, 32'd0);
    chk("rst_mid_err_clr", {31'd0, timeout_err}, 32'd0);
    reset = 0;
    hi = 0; acks = 0;
    for (int i = 0; i < 10; i++) begin
      tick;
      if (mem_if.mem_rd || mem_if.mem_we) hi++;
      if (b_ack || a_ack) acks++;
    end
    chk("rst_mid_idle_strobes", hi, 0);
    chk("rst_mid_idle_acks", acks, 0);

    // After reset, port A must win the first contention.
    a_addr = 25'h000005; a_din = 8'h09; b_addr = 24'h000003; a_req = 1; b_req = 1;
    first = 0;
    for (int i = 0; i < 60 && first == 0; i++) begin
      tick;
      if (a_ack) first = 1;
      else if (b_ack) first = 2;
    end
    a_req = 0; b_req = 0;
    chk("rst_first_winner", first, 1);
    tick; tick;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
